// File: rtl/dff_share_arb.sv
// dff_share_arb: round-robin arbiter that sequences N requesters onto one
// shared W-bit storage register. A granted requester writes once per clock
// and may extend its tenure with its lock line, up to MAX_HOLD writes.
module dff_share_arb #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 c,
    input  logic                 r,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         lock,
    input  logic [N*W-1:0]       d,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic                 q_valid,
    output logic [$clog2(N)-1:0] q_src,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First requester at or after 'start' (wrapping); MSB flags a winner.
    function automatic logic [IW:0] pick(input logic [N-1:0] rq,
                                         input logic [IW-1:0] start);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = '0;
        idx = start;
        for (int k = 0; k < N; k++) begin
            if (rq[idx] && !res[IW]) begin
                res = {1'b1, idx};
            end
            if (idx == LAST_IDX) begin
                idx = '0;
            end else begin
                idx = idx + IW'(1);
            end
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t        state_r, state_s;
    logic [N-1:0]  gnt_r, gnt_s;
    logic [IW-1:0] g_r, g_s;
    logic [IW-1:0] ptr_r, ptr_s;
    logic [HW-1:0] hcnt_r, hcnt_s;
    logic [W-1:0]  q_r, q_s;
    logic          q_valid_r, q_valid_s;
    logic [IW-1:0] q_src_r, q_src_s;
    logic          busy_r;

    logic          wr_s;
    logic          keep_s;
    logic [N-1:0]  masked_req_s;
    logic [IW:0]   win_s;
    logic [IW-1:0] g_next_s;
    logic [W-1:0]  cur_data_s;

    // Next-state logic: arbitration, write decision and tenure hold/release.
    always_comb begin
        state_s      = state_r;
        gnt_s        = gnt_r;
        g_s          = g_r;
        ptr_s        = ptr_r;
        hcnt_s       = hcnt_r;
        q_s          = q_r;
        q_valid_s    = 1'b0;
        q_src_s      = q_src_r;
        wr_s         = 1'b0;
        keep_s       = 1'b0;
        masked_req_s = req;
        cur_data_s   = d[g_r*W +: W];
        win_s        = pick(req, ptr_r);
        if (g_r == LAST_IDX) begin
            g_next_s = '0;
        end else begin
            g_next_s = g_r + IW'(1);
        end

        case (state_r)
            IDLE: begin
                if (win_s[IW]) begin
                    state_s = GRANT;
                    g_s     = win_s[IW-1:0];
                    gnt_s   = onehot(win_s[IW-1:0]);
                    hcnt_s  = '0;
                end else begin
                    state_s = IDLE;
                    gnt_s   = '0;
                end
            end
            GRANT: begin
                wr_s   = req[g_r];
                keep_s = wr_s && lock[g_r] && (hcnt_r < HOLD_LAST);
                if (wr_s) begin
                    q_s       = cur_data_s;
                    q_src_s   = g_r;
                    q_valid_s = 1'b1;
                end else begin
                    q_valid_s = 1'b0;
                end
                if (keep_s) begin
                    hcnt_s = hcnt_r + HW'(1);
                end else begin
                    // The releasing requester cannot win the re-arbitration
                    // on the same edge: if it wrote it is masked, and if it
                    // abandoned its req bit is already low.
                    ptr_s             = g_next_s;
                    masked_req_s[g_r] = 1'b0;
                    win_s             = pick(masked_req_s, g_next_s);
                    hcnt_s            = '0;
                    if (win_s[IW]) begin
                        state_s = GRANT;
                        g_s     = win_s[IW-1:0];
                        gnt_s   = onehot(win_s[IW-1:0]);
                    end else begin
                        state_s = IDLE;
                        gnt_s   = '0;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                gnt_s   = '0;
                hcnt_s  = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any tenure without a write.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            state_r   <= IDLE;
            gnt_r     <= '0;
            g_r       <= '0;
            ptr_r     <= '0;
            hcnt_r    <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            q_src_r   <= '0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            g_r       <= g_s;
            ptr_r     <= ptr_s;
            hcnt_r    <= hcnt_s;
            q_r       <= q_s;
            q_valid_r <= q_valid_s;
            q_src_r   <= q_src_s;
            busy_r    <= |gnt_s;
        end
    end

    assign gnt     = gnt_r;
    assign q       = q_r;
    assign q_valid = q_valid_r;
    assign q_src   = q_src_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_dff_share_arb.sv
// Testbench for dff_share_arb: directed vector table, hand-written reset
// sequences, and a randomized run against a behavioural reference model.
module tb_dff_share_arb;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;
    localparam int IW       = $clog2(N);

    logic           c;
    logic           r;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [IW-1:0]  q_src;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    dff_share_arb #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .c       (c),
        .r       (r),
        .req     (req),
        .lock    (lock),
        .d       (d),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_src   (q_src),
        .busy    (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] eg, input logic [W-1:0] eq,
                             input logic eqv, input logic [IW-1:0] eqs);
        check({tag, ".gnt"},     32'(gnt),     32'(eg));
        check({tag, ".q"},       32'(q),       32'(eq));
        check({tag, ".q_valid"}, 32'(q_valid), 32'(eqv));
        check({tag, ".q_src"},   32'(q_src),   32'(eqs));
        check({tag, ".busy"},    32'(busy),    32'(|eg));
        check({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    // One active edge, then settle 1 unit so outputs are sampled away from it.
    task automatic step();
        @(posedge c);
        #1;
    endtask

    // Reset pulse placed between edges; outputs must clear with no edge.
    task automatic do_reset(input string tag);
        r = 1'b1;
        #1;
        check_all(tag, 4'b0000, 8'h00, 1'b0, 2'd0);
        #1;
        r = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_g;      // granted requester, -1 when none
    int          m_ptr;
    int          m_wc;     // writes made in the current tenure
    logic [W-1:0] m_q;
    int          m_qs;
    logic        m_qv;

    function automatic int ref_pick(input logic [N-1:0] rq, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1; m_ptr = 0; m_wc = 0; m_q = '0; m_qs = 0; m_qv = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] rq, input logic [N-1:0] lk, input logic [N*W-1:0] dd);
        logic [N-1:0] others;
        if (m_g < 0) begin
            m_qv = 1'b0;
            m_g  = ref_pick(rq, m_ptr);
            m_wc = 0;
        end else begin
            if (rq[m_g]) begin
                m_q  = dd[m_g*W +: W];
                m_qs = m_g;
                m_qv = 1'b1;
                m_wc = m_wc + 1;
            end else begin
                m_qv = 1'b0;
            end
            if (!(rq[m_g] && lk[m_g] && m_wc < MAX_HOLD)) begin
                m_ptr = (m_g + 1) % N;
                others = rq;
                others[m_g] = 1'b0;
                m_g  = ref_pick(others, m_ptr);
                m_wc = 0;
            end
        end
    endtask

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] v;
        v = '0;
        if (m_g >= 0) v[m_g] = 1'b1;
        return v;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N-1:0]   lock;
        logic [N*W-1:0] d;
        logic [N-1:0]   eg;
        logic [W-1:0]   eq;
        logic           eqv;
        logic [IW-1:0]  eqs;
    } vec_t;

    vec_t vecs[18];

    initial begin
        r    = 1'b1;
        req  = '0;
        lock = '0;
        d    = '0;
        repeat (2) @(posedge c);
        #1;
        check_all("por", 4'b0000, 8'h00, 1'b0, 2'd0);
        r = 1'b0;

        // single request
        vecs[0]  = '{1'b1, 4'b0010, 4'b0000, 32'h0000A500, 4'b0010, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 4'b0010, 4'b0000, 32'h0000A500, 4'b0000, 8'hA5, 1'b1, 2'd1};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 32'h0000A500, 4'b0000, 8'hA5, 1'b0, 2'd1};
        // round robin
        vecs[3]  = '{1'b1, 4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h00, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 32'h13121110, 4'b0010, 8'h10, 1'b1, 2'd0};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0000, 32'h13121110, 4'b0100, 8'h11, 1'b1, 2'd1};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 32'h13121110, 4'b1000, 8'h12, 1'b1, 2'd2};
        vecs[7]  = '{1'b0, 4'b1111, 4'b0000, 32'h13121110, 4'b0001, 8'h13, 1'b1, 2'd3};
        // hold cap
        vecs[8]  = '{1'b1, 4'b0101, 4'b0001, 32'h00AA0055, 4'b0001, 8'h00, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 4'b0101, 4'b0001, 32'h00AA0055, 4'b0001, 8'h55, 1'b1, 2'd0};
        vecs[10] = '{1'b0, 4'b0101, 4'b0001, 32'h00AA0055, 4'b0001, 8'h55, 1'b1, 2'd0};
        vecs[11] = '{1'b0, 4'b0101, 4'b0001, 32'h00AA0055, 4'b0001, 8'h55, 1'b1, 2'd0};
        vecs[12] = '{1'b0, 4'b0101, 4'b0001, 32'h00AA0055, 4'b0100, 8'h55, 1'b1, 2'd0};
        vecs[13] = '{1'b0, 4'b0101, 4'b0001, 32'h00AA0055, 4'b0001, 8'hAA, 1'b1, 2'd2};
        // abandon: move grant to requester 3, then drop its request
        vecs[14] = '{1'b0, 4'b1000, 4'b0000, 32'h00000077, 4'b1000, 8'hAA, 1'b0, 2'd2};
        vecs[15] = '{1'b0, 4'b0001, 4'b0000, 32'h00000077, 4'b0001, 8'hAA, 1'b0, 2'd2};
        vecs[16] = '{1'b0, 4'b0001, 4'b0000, 32'h00000077, 4'b0000, 8'h77, 1'b1, 2'd0};
        vecs[17] = '{1'b0, 4'b0000, 4'b0000, 32'h00000077, 4'b0000, 8'h77, 1'b0, 2'd0};

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst) do_reset($sformatf("vec%0d.rst", i));
            req  = vecs[i].req;
            lock = vecs[i].lock;
            d    = vecs[i].d;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eq, vecs[i].eqv, vecs[i].eqs);
        end

        // async reset while requester 2 holds the register with q=0x3C
        do_reset("ar.pre");
        req = 4'b0100; lock = 4'b0000; d = 32'h003C0000;
        step();
        check_all("ar.grant", 4'b0100, 8'h00, 1'b0, 2'd0);
        lock = 4'b0100;
        step();
        check_all("ar.write", 4'b0100, 8'h3C, 1'b1, 2'd2);
        do_reset("ar.reset");

        // reset in the middle of a locked tenure of requester 1 (hcnt=2)
        req = 4'b0010; lock = 4'b0010; d = 32'h00003300;
        step();
        check_all("ml.grant", 4'b0010, 8'h00, 1'b0, 2'd0);
        step();
        step();
        check_all("ml.hold", 4'b0010, 8'h33, 1'b1, 2'd1);
        do_reset("ml.reset");
        lock = 4'b0000;
        step();
        check_all("ml.regrant", 4'b0010, 8'h00, 1'b0, 2'd0);
        req = 4'b1010;
        step();
        check_all("ml.write", 4'b1000, 8'h33, 1'b1, 2'd1);

        // randomized run against the reference model
        do_reset("rnd.rst");
        model_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) req = N'($urandom);
            lock = N'($urandom);
            for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
            model_edge(req, lock, d);
            step();
            check_all($sformatf("rnd%0d", i), model_gnt(), m_q, m_qv, IW'(m_qs));
            if ($urandom_range(0, 49) == 0) begin
                do_reset($sformatf("rnd%0d.rst", i));
                model_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
